diverge_pipe: RTL and testbench
===============================

Name: diverge_pipe

Overview:
- One iteration stage of the Mandelbrot escape-time pipeline.
- Computes z' = z² + c for the point it holds. Detects escape and counts the iterations survived.
- N instances are chained (newX→x, …, new_no_op→no_op) to form the fractal iteration pipeline between the pixel/coordinate generator and the colour mapper.
- One registered stage, one clock of latency.

Parameters:
- W, 16: width of x, y, c1, c2. Signed two's complement, Q2.14 fixed point (0x4000 = 1.0, range -2.0 to +1.99994).
- FRAC, 14: number of fractional bits.
- DW, 8: width of the iteration counter div/newDiv.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- x  in  W  real part of z, Q2.14.
- y  in  W  imaginary part of z, Q2.14.
- c1  in  W  real part of c, Q2.14.
- c2  in  W  imaginary part of c, Q2.14.
- div  in  DW  iterations completed so far.
- no_op  in  1  1 = bubble or already-escaped point; pass through untouched.
- stage  in  1  stage enable. 1 = capture a new result this edge; 0 = hold all outputs.
- newX  out  W  registered real part of next z.
- newY  out  W  registered imaginary part of next z.
- newC1  out  W  registered copy of c1.
- newC2  out  W  registered copy of c2.
- newDiv  out  DW  registered iteration count.
- new_no_op  out  1  registered escaped/bubble flag.

Behaviour:
- Interface: one clock (Clk); Reset is synchronous and active-high.
- Reset (checked at the Clk edge, has priority over stage): newX, newY, newC1, newC2 and newDiv go to 0; new_no_op goes to 1 (the stage holds a bubble). Reset asserted mid-stream discards the held point.
- stage=0 and Reset=0: all outputs hold their previous values.
- stage=1: all outputs are updated at the edge from the current inputs. Latency is exactly 1 cycle. Combinational inputs-to-outputs paths are not allowed.
- newC1 = c1 and newC2 = c2 in every case.
- Arithmetic, all signed and full precision:
  - xx = x·x, yy = y·y, xy = x·y, each 32-bit Q4.28.
  - re = xx − yy + (c1 <<< 14), 34-bit.
  - im = 2·xy + (c2 <<< 14), 34-bit.
  - Result = arithmetic shift right by 14 (truncate toward −∞).
- mag = xx + yy, unsigned 33-bit.
- escape = (mag > 4.0, i.e. mag > 0x4000_0000), OR re>>>14 outside [-32768, 32767], OR im>>>14 outside [-32768, 32767].
- no_op=1: newX=x, newY=y, newDiv=div, new_no_op=1.
- no_op=0 and escape=1: newX=x, newY=y, newDiv=div, new_no_op=1. The point freezes at its last in-range value.
- no_op=0 and escape=0: newX=re>>>14 (low 16 bits), newY=im>>>14, new_no_op=0. newDiv=div+1, saturating at 2^DW−1 (255 stays 255).
- mag exactly equal to 4.0 does not escape.

Test Plan:
1. Reset=1 for one edge with arbitrary inputs, stage=1 -> newX=newY=newC1=newC2=0, newDiv=0, new_no_op=1.
2. x=y=c1=c2=0x4000 (1.0), div=0, no_op=0, stage=1 -> mag=2.0 but im=3.0 overflows. Result: newX=0x4000, newY=0x4000, newC1=newC2=0x4000, newDiv=0, new_no_op=1.
3. x=0x6000 (1.5), y=c1=c2=0x4000, div=0, no_op=0, stage=1 -> re=2.25 overflows. Result: newX=0x6000, newY=0x4000, newDiv=0, new_no_op=1.
4. x=y=0x2000 (0.5), c1=c2=0, div=5, no_op=0, stage=1 -> newX=0x0000, newY=0x2000, newDiv=6, new_no_op=0.
   - Follow-up: x=0xC000 (−1.0), y=0, c1=0xC000, c2=0 -> newX=0, newY=0, newDiv incremented.
5. x=y=0x7FFF, c1=c2=0, no_op=0 -> mag≈8 > 4, escape: newX=newY=0x7FFF, newDiv=div, new_no_op=1.
   - Separately: div=255 on a non-escaping point -> newDiv=255.
6. After a valid capture, drive new inputs with stage=0 for 3 cycles -> outputs unchanged.
   - Then no_op=1, div=9, x=0x1234, stage=1 -> newX=0x1234, newDiv=9, new_no_op=1.

Source files
------------

// File: rtl/diverge_pipe.sv
// diverge_pipe: one registered iteration stage of the Mandelbrot escape-time
// pipeline. It computes z' = z^2 + c in Q2.14 fixed point, flags escape, and
// counts the iterations the point has survived. Chain N of these stages to
// build the fractal iteration pipeline.
module diverge_pipe #(
  parameter int W    = 16,
  parameter int FRAC = 14,
  parameter int DW   = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  input  logic [W-1:0]  c1,
  input  logic [W-1:0]  c2,
  input  logic [DW-1:0] div,
  input  logic          no_op,
  input  logic          stage,
  output logic [W-1:0]  newX,
  output logic [W-1:0]  newY,
  output logic [W-1:0]  newC1,
  output logic [W-1:0]  newC2,
  output logic [DW-1:0] newDiv,
  output logic          new_no_op
);

  localparam int PW = 2 * W;        // product width, Q4.28
  localparam int SW = PW + 2;       // sum width, keeps the carries
  localparam int RW = SW - FRAC;    // width after the fractional shift

  logic signed [PW-1:0] xx, yy, xy;
  logic signed [SW-1:0] xx_e, yy_e, xy_e, c1_e, c2_e;
  logic signed [SW-1:0] re, im;
  logic signed [RW-1:0] re_s, im_s;
  logic        [PW:0]   mag;
  logic                 re_ok, im_ok, escape;
  logic        [DW-1:0] div_inc;
  logic                 unused_frac;

  // Squared and cross terms, widened sums, escape test and saturating count.
  always_comb begin
    xx   = $signed(x) * $signed(x);
    yy   = $signed(y) * $signed(y);
    xy   = $signed(x) * $signed(y);
    xx_e = SW'(xx);
    yy_e = SW'(yy);
    xy_e = SW'(xy);
    c1_e = SW'($signed(c1));
    c2_e = SW'($signed(c2));
    re   = xx_e - yy_e + (c1_e <<< FRAC);
    im   = (xy_e <<< 1) + (c2_e <<< FRAC);
    // Keeping only the upper bits is an arithmetic shift right by FRAC,
    // i.e. truncation toward minus infinity.
    re_s = re[SW-1:FRAC];
    im_s = im[SW-1:FRAC];
    unused_frac = ^{re[FRAC-1:0], im[FRAC-1:0]};
    // The squares are never negative, so zero extension is exact.
    mag  = {1'b0, xx} + {1'b0, yy};
    // In range when every bit above the W-bit sign bit matches it.
    re_ok  = (re_s[RW-1:W-1] == '0) || (re_s[RW-1:W-1] == '1);
    im_ok  = (im_s[RW-1:W-1] == '0) || (im_s[RW-1:W-1] == '1);
    escape = (mag > (PW+1)'(1) << (PW - 2)) || !re_ok || !im_ok;
    div_inc = (div == '1) ? div : div + 1'b1;
  end

  // Stage register: reset to a bubble, hold when stage is low.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      newX      <= '0;
      newY      <= '0;
      newC1     <= '0;
      newC2     <= '0;
      newDiv    <= '0;
      new_no_op <= 1'b1;
    end else if (stage) begin
      newC1 <= c1;
      newC2 <= c2;
      if (no_op || escape) begin
        newX      <= x;
        newY      <= y;
        newDiv    <= div;
        new_no_op <= 1'b1;
      end else begin
        newX      <= re_s[W-1:0];
        newY      <= im_s[W-1:0];
        newDiv    <= div_inc;
        new_no_op <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_diverge_pipe.sv
// tb_diverge_pipe: directed, table-driven check of one diverge_pipe stage.
module tb_diverge_pipe;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] x, y, c1, c2;
  logic [7:0]  div;
  logic        no_op, stage;
  logic [15:0] newX, newY, newC1, newC2;
  logic [7:0]  newDiv;
  logic        new_no_op;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] x, y, c1, c2;
    logic [7:0]  div;
    logic        nop;
    logic [15:0] ex, ey;
    logic [7:0]  ediv;
    logic        enop;
  } vec_t;

  vec_t tbl[13];

  diverge_pipe #(.W(16), .FRAC(14), .DW(8)) dut (
    .Clk(Clk), .Reset(Reset), .x(x), .y(y), .c1(c1), .c2(c2), .div(div),
    .no_op(no_op), .stage(stage), .newX(newX), .newY(newY), .newC1(newC1),
    .newC2(newC2), .newDiv(newDiv), .new_no_op(new_no_op)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [15:0] ex, ey, ec1, ec2,
                       input logic [7:0] ed, input logic en);
    vectors++;
    if (newX !== ex) begin
      $display("FAIL %s newX got %h want %h", name, newX, ex); miscompares++;
    end
    if (newY !== ey) begin
      $display("FAIL %s newY got %h want %h", name, newY, ey); miscompares++;
    end
    if (newC1 !== ec1) begin
      $display("FAIL %s newC1 got %h want %h", name, newC1, ec1); miscompares++;
    end
    if (newC2 !== ec2) begin
      $display("FAIL %s newC2 got %h want %h", name, newC2, ec2); miscompares++;
    end
    if (newDiv !== ed) begin
      $display("FAIL %s newDiv got %0d want %0d", name, newDiv, ed); miscompares++;
    end
    if (new_no_op !== en) begin
      $display("FAIL %s new_no_op got %b want %b", name, new_no_op, en); miscompares++;
    end
  endtask

  task automatic drive(input logic [15:0] ix, iy, ic1, ic2, input logic [7:0] id,
                       input logic inop, input logic istage, input logic irst);
    x = ix; y = iy; c1 = ic1; c2 = ic2; div = id;
    no_op = inop; stage = istage; Reset = irst;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    //           x        y        c1       c2       div nop  ex       ey       ediv enop
    tbl[0]  = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 0,   0, 16'h4000, 16'h4000, 0,   1}; // im = 3.0 overflows
    tbl[1]  = '{16'h6000, 16'h4000, 16'h4000, 16'h4000, 0,   0, 16'h6000, 16'h4000, 0,   1}; // re = 2.25 overflows
    tbl[2]  = '{16'h2000, 16'h2000, 16'h0000, 16'h0000, 5,   0, 16'h0000, 16'h2000, 6,   0};
    tbl[3]  = '{16'hC000, 16'h0000, 16'hC000, 16'h0000, 6,   0, 16'h0000, 16'h0000, 7,   0};
    tbl[4]  = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 17,  0, 16'h7FFF, 16'h7FFF, 17,  1}; // mag ~ 8
    tbl[5]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 255, 0, 16'h0000, 16'h0000, 255, 0}; // saturate
    tbl[6]  = '{16'h0000, 16'h0001, 16'h0000, 16'h0000, 3,   0, 16'hFFFF, 16'h0000, 4,   0}; // floor of -1 LSB
    tbl[7]  = '{16'h2000, 16'hE000, 16'h0000, 16'h0000, 254, 0, 16'h0000, 16'hE000, 255, 0}; // negative im
    tbl[8]  = '{16'h7FFF, 16'h00FF, 16'h8000, 16'h0000, 10,  0, 16'h7FF8, 16'h03FB, 11,  0}; // mag just under 4
    tbl[9]  = '{16'h7FFF, 16'h0100, 16'h8000, 16'h0000, 10,  0, 16'h7FFF, 16'h0100, 10,  1}; // mag = 4 + 1 LSB
    tbl[10] = '{16'h5A82, 16'h5A82, 16'h0000, 16'h8000, 20,  0, 16'h0000, 16'h7FFD, 21,  0}; // im near top
    tbl[11] = '{16'h1234, 16'h5678, 16'h1111, 16'h2222, 9,   1, 16'h1234, 16'h5678, 9,   1}; // bubble
    tbl[12] = '{16'h0000, 16'h7FFF, 16'h8000, 16'h0000, 3,   0, 16'h0000, 16'h7FFF, 3,   1}; // re underflows

    // Reset with stage high and arbitrary inputs.
    drive(16'h1357, 16'h2468, 16'h1111, 16'h2222, 8'd42, 1'b0, 1'b1, 1'b1);
    check("reset", 16'h0, 16'h0, 16'h0, 16'h0, 8'd0, 1'b1);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].x, tbl[i].y, tbl[i].c1, tbl[i].c2, tbl[i].div, tbl[i].nop, 1'b1, 1'b0);
      check($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].c1, tbl[i].c2,
            tbl[i].ediv, tbl[i].enop);
    end

    // Valid capture, then three cycles of stage low with changing inputs.
    drive(16'h2000, 16'h2000, 16'h0000, 16'h0000, 8'd5, 1'b0, 1'b1, 1'b0);
    check("capture", 16'h0000, 16'h2000, 16'h0000, 16'h0000, 8'd6, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(16'h1000 + 16'(k), 16'h0100, 16'h0ABC, 16'h0DEF, 8'(k + 100), 1'(k & 1), 1'b0, 1'b0);
      check($sformatf("hold%0d", k), 16'h0000, 16'h2000, 16'h0000, 16'h0000, 8'd6, 1'b0);
    end

    // Bubble passes through untouched.
    drive(16'h1234, 16'h0000, 16'h0000, 16'h0000, 8'd9, 1'b1, 1'b1, 1'b0);
    check("bubble", 16'h1234, 16'h0000, 16'h0000, 16'h0000, 8'd9, 1'b1);

    // Load a live point, then reset with stage low: reset wins and discards it.
    drive(16'hC000, 16'h0000, 16'hC000, 16'h0000, 8'd30, 1'b0, 1'b1, 1'b0);
    check("live", 16'h0000, 16'h0000, 16'hC000, 16'h0000, 8'd31, 1'b0);
    drive(16'h4000, 16'h4000, 16'h4000, 16'h4000, 8'd7, 1'b0, 1'b0, 1'b1);
    check("reset_mid", 16'h0, 16'h0, 16'h0, 16'h0, 8'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
